// File: rtl/rnn_ram_loader.sv
// rnn_ram_loader: packs a W,H,U,X,V word stream into five-bank parameter RAM
// writes at consecutive addresses starting from a programmed base address.
module rnn_ram_loader #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 32,
    parameter int RAMSIZE = 512
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   num_entries,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              writeenable,
    output logic [ADDR_W-1:0] writeport,
    output logic [DATA_W-1:0] writeW,
    output logic [DATA_W-1:0] writeH,
    output logic [DATA_W-1:0] writeU,
    output logic [DATA_W-1:0] writeX,
    output logic [DATA_W-1:0] writeV,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [ADDR_W:0]   MAX_ENTRIES = (ADDR_W+1)'(RAMSIZE);
    localparam logic [ADDR_W:0]   REM_ONE     = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE    = ADDR_W'(1);

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W:0]     remaining_q;
    logic [2:0]          field_q;
    // Only W,H,U,X need holding; V is forwarded straight from the fifth word.
    logic [DATA_W-1:0]   hold_q [0:3];

    logic                writeenable_q;
    logic [ADDR_W-1:0]   writeport_q;
    logic [DATA_W-1:0]   writew_q, writeh_q, writeu_q, writex_q, writev_q;
    logic                busy_q, done_q, err_q;

    assign in_ready    = (state_q == S_COLLECT);
    assign writeenable = writeenable_q;
    assign writeport   = writeport_q;
    assign writeW      = writew_q;
    assign writeH      = writeh_q;
    assign writeU      = writeu_q;
    assign writeX      = writex_q;
    assign writeV      = writev_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;

    // Load sequencer: collects five words, issues one registered RAM write per entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            remaining_q   <= '0;
            field_q       <= '0;
            for (int i = 0; i < 4; i++) hold_q[i] <= '0;
            writeenable_q <= 1'b0;
            writeport_q   <= '0;
            writew_q      <= '0;
            writeh_q      <= '0;
            writeu_q      <= '0;
            writex_q      <= '0;
            writev_q      <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            // Strobes default low so each lasts exactly one cycle.
            writeenable_q <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (num_entries == '0) begin
                            done_q <= 1'b1;
                        end else if (num_entries > MAX_ENTRIES) begin
                            err_q <= 1'b1;
                        end else begin
                            addr_q      <= base_addr;
                            remaining_q <= num_entries;
                            field_q     <= '0;
                            busy_q      <= 1'b1;
                            state_q     <= S_COLLECT;
                        end
                    end
                end
                S_COLLECT: begin
                    // in_ready is high here, so in_valid alone is the handshake.
                    if (in_valid) begin
                        if (field_q == 3'd4) begin
                            writeenable_q <= 1'b1;
                            writeport_q   <= addr_q;
                            writew_q      <= hold_q[0];
                            writeh_q      <= hold_q[1];
                            writeu_q      <= hold_q[2];
                            writex_q      <= hold_q[3];
                            writev_q      <= in_data;
                            field_q       <= '0;
                            state_q       <= S_WRITE;
                        end else begin
                            hold_q[field_q[1:0]] <= in_data;
                            field_q              <= field_q + 3'd1;
                        end
                    end
                end
                S_WRITE: begin
                    // Address wraps naturally at 2^ADDR_W.
                    addr_q      <= addr_q + ADDR_ONE;
                    remaining_q <= remaining_q - REM_ONE;
                    if (remaining_q == REM_ONE) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_DONE;
                    end else begin
                        state_q <= S_COLLECT;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rnn_ram_loader.sv
// tb_rnn_ram_loader: scoreboard bench; stimulus pushes expected RAM writes,
// a negedge monitor pops and compares each observed write.
module tb_rnn_ram_loader;

    logic        clk = 1'b0;
    logic        reset, start, in_valid;
    logic [8:0]  base_addr;
    logic [9:0]  num_entries;
    logic [31:0] in_data;
    logic        in_ready, writeenable, busy, done, err;
    logic [8:0]  writeport;
    logic [31:0] writeW, writeH, writeU, writeX, writeV;

    rnn_ram_loader #(.ADDR_W(9), .DATA_W(32), .RAMSIZE(512)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .num_entries(num_entries), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .writeenable(writeenable), .writeport(writeport),
        .writeW(writeW), .writeH(writeH), .writeU(writeU), .writeX(writeX),
        .writeV(writeV), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [8:0]   a;
        logic [159:0] d;
    } wr_t;

    int           checks = 0;
    int           fails  = 0;
    int           cyc    = 0;
    int           last_wr_cyc = 0;
    int           done_cyc = 0;
    wr_t          exp_q[$];
    int           wtimes[$];
    logic [159:0] ram [512];
    int           hits [512];
    wr_t          got_w, exp_w;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h", nm, act, req);
        end
    endtask

    // Write monitor: every observed write is checked against the scoreboard.
    always @(negedge clk) begin
        if (writeenable) begin
            got_w = {writeport, writeW, writeH, writeU, writeX, writeV};
            wtimes.push_back(cyc);
            last_wr_cyc = cyc;
            ram[writeport] = got_w.d;
            hits[writeport]++;
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_write: actual addr %0d data %0h required none", writeport, got_w.d);
            end else begin
                exp_w = exp_q.pop_front();
                $display("write addr=%0d data=%040h expected addr=%0d", writeport, got_w.d, exp_w.a);
                chk("write", 192'(got_w), 192'(exp_w));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int b, input int n);
        base_addr   = 9'(b);
        num_entries = 10'(n);
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    task automatic send(input logic [31:0] d, input bit stall);
        bit hs;
        int t;
        hs = 1'b0;
        t  = 0;
        in_data  = d;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            hs = in_ready;
            tick();
            t++;
        end while (!hs && t < 100);
        if (!hs) chk("send_timeout", 0, 1);
        if (stall) begin
            in_valid = 1'b0;
            in_data  = 32'hDEADBEEF;
            tick();
        end
    endtask

    task automatic push_exp(input int b, input int k, input logic [31:0] d0);
        wr_t e;
        logic [31:0] w;
        e.a = 9'(b + k);
        e.d = '0;
        for (int f = 0; f < 5; f++) begin
            w   = d0 + 32'(5 * k + f);
            e.d = {e.d[127:0], w};
        end
        exp_q.push_back(e);
    endtask

    task automatic load(input int b, input int n, input logic [31:0] d0, input bit stall);
        do_start(b, n);
        for (int k = 0; k < n; k++) begin
            push_exp(b, k, d0);
            for (int f = 0; f < 5; f++) send(d0 + 32'(5 * k + f), stall);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_end(input bit exp_done, input string nm, output bit seen_busy);
        int t;
        t = 0;
        seen_busy = 1'b0;
        do begin
            @(negedge clk);
            if (busy) seen_busy = 1'b1;
            t++;
        end while (!(done || err) && t < 40);
        done_cyc = cyc;
        chk({nm, "_done"}, 192'(done), 192'(exp_done));
        chk({nm, "_err"}, 192'(err), 192'(!exp_done));
        @(negedge clk);
        chk({nm, "_pulse_width"}, 192'({done, err}), 192'(0));
        chk({nm, "_busy_after"}, 192'(busy), 192'(0));
        chk({nm, "_queue_empty"}, 192'(exp_q.size()), 192'(0));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit sb;
        logic [159:0] dd;
        logic [31:0]  w;
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        base_addr = '0; num_entries = '0;
        for (int i = 0; i < 512; i++) begin hits[i] = 0; ram[i] = '0; end
        repeat (3) tick();
        reset = 1'b0;
        chk("reset_we", 192'(writeenable), 0);
        chk("reset_port", 192'(writeport), 0);
        chk("reset_data", 192'({writeW, writeH, writeU, writeX, writeV}), 0);
        chk("reset_flags", 192'({busy, done, err, in_ready}), 0);

        // 1: single entry, in_valid always high
        do_start(5, 1);
        chk("t1_busy", 192'(busy), 1);
        chk("t1_ready", 192'(in_ready), 1);
        push_exp(5, 0, 32'd1);
        for (int f = 0; f < 5; f++) send(32'd1 + 32'(f), 1'b0);
        in_valid = 1'b0;
        wait_end(1'b1, "t1", sb);
        chk("t1_done_latency", 192'(done_cyc - last_wr_cyc), 1);

        // 2: back-to-back entries, 6 cycles apart
        wtimes.delete();
        load(0, 3, 32'h10, 1'b0);
        wait_end(1'b1, "t2", sb);
        chk("t2_nwrites", 192'(wtimes.size()), 3);
        if (wtimes.size() == 3) begin
            chk("t2_gap0", 192'(wtimes[1] - wtimes[0]), 6);
            chk("t2_gap1", 192'(wtimes[2] - wtimes[1]), 6);
        end

        // 3: address wrap 510,511,0,1
        load(510, 4, 32'h300, 1'b0);
        wait_end(1'b1, "t3", sb);

        // 4: stalled stream, junk on in_valid-low cycles
        load(40, 1, 32'hA0, 1'b1);
        wait_end(1'b1, "t4", sb);

        // 5a/5b: zero entries and out-of-range count
        do_start(9, 0);
        wait_end(1'b1, "t5_zero", sb);
        do_start(9, 513);
        wait_end(1'b0, "t5_big", sb);
        chk("t5_big_busy_seen", 192'(sb), 0);

        // 6: reset in the middle of entry 2
        do_start(20, 3);
        push_exp(20, 0, 32'h500);
        for (int f = 0; f < 8; f++) send(32'h500 + 32'(f), 1'b0);
        in_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_we", 192'(writeenable), 0);
        chk("t6_port_data", 192'({writeport, writeW, writeV}), 0);
        chk("t6_flags", 192'({busy, done, err, in_ready}), 0);
        repeat (8) tick();
        chk("t6_queue_empty", 192'(exp_q.size()), 0);
        load(7, 1, 32'h777, 1'b0);
        wait_end(1'b1, "t6_reload", sb);

        // 5c/7: full 512-entry load with ignored starts during busy
        for (int i = 0; i < 512; i++) hits[i] = 0;
        fork
            load(0, 512, 32'h1000_0000, 1'b0);
            begin
                #500;
                for (int r = 0; r < 4; r++) begin
                    base_addr   = 9'd100;
                    num_entries = (r % 2 == 0) ? 10'd3 : 10'd513;
                    start       = 1'b1;
                    tick();
                    start       = 1'b0;
                    @(negedge clk);
                    chk("t7_busy_start_ignored", 192'({done, err, busy}), 192'(1));
                    repeat (40) tick();
                end
            end
        join
        wait_end(1'b1, "t7", sb);
        for (int a = 0; a < 512; a++) begin
            dd = '0;
            for (int f = 0; f < 5; f++) begin
                w  = 32'h1000_0000 + 32'(5 * a + f);
                dd = {dd[127:0], w};
            end
            chk("t7_hits", 192'(hits[a]), 1);
            chk("t7_ram", 192'(ram[a]), 192'(dd));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
